// File: rtl/irq_arbiter.sv
// NMOS-6502 interrupt front end: synchronises IRQ/NMI pins, latches pending state,
// arbitrates NMI-first then lowest index, and hands one request to the CPU via req/ack.
module irq_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rdy,
  input  logic [NUM_SRC-1:0] src_n,
  input  logic               nmi_n,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               i_flag,
  input  logic [NUM_SRC-1:0] sw_clr,
  input  logic               int_ack,
  output logic               int_req,
  output logic               int_is_nmi,
  output logic [IDX_W-1:0]   int_src,
  output logic [NUM_SRC-1:0] pending,
  output logic               nmi_pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] src_sync_r;
  logic [SYNC_STAGES-1:0]              nmi_sync_r;
  logic [NUM_SRC-1:0]                  src_prev_r;
  logic                                nmi_prev_r;
  logic [NUM_SRC-1:0]                  pending_r;
  logic                                nmi_pending_r;
  state_t                              state_r;
  logic                                int_req_r;
  logic                                int_is_nmi_r;
  logic [IDX_W-1:0]                    int_src_r;

  logic [NUM_SRC-1:0] src_sync_s;
  logic [NUM_SRC-1:0] src_fall_s;
  logic               nmi_fall_s;
  logic [NUM_SRC-1:0] elig_s;
  logic               irq_any_s;
  logic               any_s;
  logic               presented_ok_s;
  logic [IDX_W-1:0]   low_idx_s;
  logic [NUM_SRC-1:0] svc_clr_s;
  logic               svc_nmi_s;
  logic [NUM_SRC-1:0] pending_nx_s;
  logic               nmi_pending_nx_s;
  state_t             state_nx_s;
  logic               int_req_nx_s;
  logic               int_is_nmi_nx_s;
  logic [IDX_W-1:0]   int_src_nx_s;

  assign src_sync_s     = src_sync_r[SYNC_STAGES-1];
  assign src_fall_s     = src_prev_r & ~src_sync_s;
  assign nmi_fall_s     = nmi_prev_r & ~nmi_sync_r[SYNC_STAGES-1];
  assign elig_s         = pending_r & src_mask;
  assign irq_any_s      = (|elig_s) & ~i_flag;
  assign any_s          = nmi_pending_r | irq_any_s;
  assign presented_ok_s = pending_r[int_src_r] & src_mask[int_src_r] & ~i_flag;

  // Pin synchronisers and previous-value flops; they idle at 1 (inactive).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_sync_r <= '1;
      nmi_sync_r <= '1;
      src_prev_r <= '1;
      nmi_prev_r <= 1'b1;
    end else begin
      src_sync_r <= {src_sync_r[SYNC_STAGES-2:0], src_n};
      nmi_sync_r <= {nmi_sync_r[SYNC_STAGES-2:0], nmi_n};
      src_prev_r <= src_sync_s;
      nmi_prev_r <= nmi_sync_r[SYNC_STAGES-1];
    end
  end

  // Lowest-index eligible source, scanned from the top so the lowest one wins.
  always_comb begin
    low_idx_s = {IDX_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      low_idx_s = elig_s[i] ? IDX_W'(i) : low_idx_s;
    end
  end

  // Arbitration FSM next state and registered-output next values; rdy=0 holds everything.
  always_comb begin
    state_nx_s      = state_r;
    int_req_nx_s    = int_req_r;
    int_is_nmi_nx_s = int_is_nmi_r;
    int_src_nx_s    = int_src_r;
    svc_clr_s       = {NUM_SRC{1'b0}};
    svc_nmi_s       = 1'b0;
    if (rdy) begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            state_nx_s      = ST_REQ;
            int_req_nx_s    = 1'b1;
            int_is_nmi_nx_s = nmi_pending_r;
            int_src_nx_s    = nmi_pending_r ? {IDX_W{1'b0}} : low_idx_s;
          end else begin
            int_req_nx_s    = 1'b0;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state_nx_s      = ST_SERVICE;
            int_req_nx_s    = 1'b0;
          end else if (!int_is_nmi_r && nmi_pending_r) begin
            int_is_nmi_nx_s = 1'b1;
            int_src_nx_s    = {IDX_W{1'b0}};
          end else if (!int_is_nmi_r && !presented_ok_s) begin
            state_nx_s      = ST_IDLE;
            int_req_nx_s    = 1'b0;
          end else if (!int_is_nmi_r) begin
            int_src_nx_s    = low_idx_s;
          end else begin
            int_src_nx_s    = {IDX_W{1'b0}};
          end
        end
        ST_SERVICE: begin
          state_nx_s   = ST_HOLDOFF;
          int_req_nx_s = 1'b0;
          if (int_is_nmi_r) begin
            svc_nmi_s = 1'b1;
          end else begin
            svc_clr_s = NUM_SRC'(1'b1) << int_src_r;
          end
        end
        ST_HOLDOFF: begin
          state_nx_s   = ST_IDLE;
          int_req_nx_s = 1'b0;
        end
        default: begin
          state_nx_s   = ST_IDLE;
          int_req_nx_s = 1'b0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // A detected edge always wins over a same-cycle clear; level sources just follow the pin.
  assign pending_nx_s = (edge_mode & (src_fall_s | (pending_r & ~(sw_clr | svc_clr_s))))
                      | (~edge_mode & ~src_sync_s);
  assign nmi_pending_nx_s = nmi_fall_s | (nmi_pending_r & ~svc_nmi_s);

  // Pending latches, FSM state and the request outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r     <= {NUM_SRC{1'b0}};
      nmi_pending_r <= 1'b0;
      state_r       <= ST_IDLE;
      int_req_r     <= 1'b0;
      int_is_nmi_r  <= 1'b0;
      int_src_r     <= {IDX_W{1'b0}};
    end else begin
      pending_r     <= pending_nx_s;
      nmi_pending_r <= nmi_pending_nx_s;
      state_r       <= state_nx_s;
      int_req_r     <= int_req_nx_s;
      int_is_nmi_r  <= int_is_nmi_nx_s;
      int_src_r     <= int_src_nx_s;
    end
  end

  assign int_req     = int_req_r;
  assign int_is_nmi  = int_is_nmi_r;
  assign int_src     = int_src_r;
  assign pending     = pending_r;
  assign nmi_pending = nmi_pending_r;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus random stimulus,
// all compared against a cycle-level behavioural reference model.
module tb_irq_arbiter;

  localparam int N = 4;
  localparam int S = 2;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         rdy;
  logic [N-1:0] src_n;
  logic         nmi_n;
  logic [N-1:0] edge_mode;
  logic [N-1:0] src_mask;
  logic         i_flag;
  logic [N-1:0] sw_clr;
  logic         int_ack;
  logic         int_req;
  logic         int_is_nmi;
  logic [W-1:0] int_src;
  logic [N-1:0] pending;
  logic         nmi_pending;

  int total = 0;
  int bad   = 0;

  irq_arbiter #(.NUM_SRC(N), .SYNC_STAGES(S), .IDX_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .rdy(rdy), .src_n(src_n), .nmi_n(nmi_n),
    .edge_mode(edge_mode), .src_mask(src_mask), .i_flag(i_flag), .sw_clr(sw_clr),
    .int_ack(int_ack), .int_req(int_req), .int_is_nmi(int_is_nmi), .int_src(int_src),
    .pending(pending), .nmi_pending(nmi_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pin samples kept as a history (dl[j] = sample taken j edges ago),
  // plus "presenting" and a post-ack quiet countdown (2 = service edge, 1 = holdoff edge).
  typedef struct packed {
    logic [S:0][N-1:0] dl_src;
    logic [S:0]        dl_nmi;
    logic [N-1:0]      pend;
    logic              nmi_p;
    logic              presenting;
    logic [1:0]        quiet;
    logic              is_nmi;
    logic [W-1:0]      src;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t r;
    r        = '0;
    r.dl_src = '1;
    r.dl_nmi = '1;
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t c);
    mstate_t      n;
    logic [N-1:0] sync, fall, elig, svc_clr;
    logic         nfall, any_irq, svc_nmi;
    int           low;
    n       = c;
    sync    = c.dl_src[S-1];
    fall    = c.dl_src[S] & ~sync;
    nfall   = c.dl_nmi[S] & ~c.dl_nmi[S-1];
    elig    = c.pend & src_mask;
    any_irq = (elig != '0) && !i_flag;
    low     = 0;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) low = i;
    svc_clr = '0;
    svc_nmi = 1'b0;
    if (rdy) begin
      if (c.quiet == 2'd2) begin
        if (c.is_nmi) svc_nmi = 1'b1;
        else svc_clr[c.src] = 1'b1;
        n.quiet = 2'd1;
      end else if (c.quiet == 2'd1) begin
        n.quiet = 2'd0;
      end else if (!c.presenting) begin
        if (c.nmi_p || any_irq) begin
          n.presenting = 1'b1;
          n.is_nmi     = c.nmi_p;
          if (c.nmi_p) n.src = '0;
          else n.src = low[W-1:0];
        end
      end else if (int_ack) begin
        n.presenting = 1'b0;
        n.quiet      = 2'd2;
      end else if (!c.is_nmi && c.nmi_p) begin
        n.is_nmi = 1'b1;
        n.src    = '0;
      end else if (!c.is_nmi && !(c.pend[c.src] && src_mask[c.src] && !i_flag)) begin
        n.presenting = 1'b0;
      end else if (!c.is_nmi) begin
        n.src = low[W-1:0];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!edge_mode[i])                 n.pend[i] = ~sync[i];
      else if (fall[i])                  n.pend[i] = 1'b1;
      else if (sw_clr[i] || svc_clr[i])  n.pend[i] = 1'b0;
    end
    if (nfall) n.nmi_p = 1'b1;
    else if (svc_nmi) n.nmi_p = 1'b0;
    n.dl_src = {c.dl_src[S-1:0], src_n};
    n.dl_nmi = {c.dl_nmi[S-1:0], nmi_n};
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= model_step(m);
  end

  always @(negedge clk) begin
    check("m_req",  32'(int_req),     32'(m.presenting));
    check("m_nmi",  32'(int_is_nmi),  32'(m.is_nmi));
    check("m_src",  32'(int_src),     32'(m.src));
    check("m_pend", 32'(pending),     32'(m.pend));
    check("m_nmip", 32'(nmi_pending), 32'(m.nmi_p));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_once();
    int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rdy = 1'b1; src_n = '1; nmi_n = 1'b1; edge_mode = '1;
    src_mask = '1; i_flag = 1'b0; sw_clr = '0; int_ack = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    check("rst_req",  32'(int_req), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);

    // Reset asserted mid-request
    src_n[1] = 1'b0;
    cyc(4);
    check("t1_req", 32'(int_req), 32'd1);
    check("t1_src", 32'(int_src), 32'd1);
    #2 reset_n = 1'b0;
    src_n[1] = 1'b1;
    #1;
    check("t1_rq0",  32'(int_req),     32'd0);
    check("t1_nm0",  32'(int_is_nmi),  32'd0);
    check("t1_sr0",  32'(int_src),     32'd0);
    check("t1_pd0",  32'(pending),     32'd0);
    check("t1_np0",  32'(nmi_pending), 32'd0);
    cyc(1);
    reset_n = 1'b1;
    cyc(6);
    check("t1_norq", 32'(int_req), 32'd0);
    check("t1_nopd", 32'(pending), 32'd0);

    // Latency and acknowledge
    src_n[2] = 1'b0;
    cyc(3);
    check("t2_pend", 32'(pending), 32'h4);
    check("t2_req0", 32'(int_req), 32'd0);
    cyc(1);
    check("t2_req1", 32'(int_req), 32'd1);
    check("t2_src",  32'(int_src), 32'd2);
    ack_once();
    check("t2_ackq", 32'(int_req), 32'd0);
    cyc(1);
    check("t2_pclr", 32'(pending), 32'd0);
    check("t2_q2",   32'(int_req), 32'd0);
    cyc(1);
    check("t2_q3",   32'(int_req), 32'd0);
    cyc(1);
    check("t2_q4",   32'(int_req), 32'd0);
    src_n[2] = 1'b1;
    cyc(3);

    // Priority replacement and NMI hijack
    src_n[3] = 1'b0;
    cyc(4);
    check("t3_src3", 32'(int_src), 32'd3);
    src_n[0] = 1'b0;
    cyc(3);
    check("t3_still3", 32'(int_src), 32'd3);
    cyc(1);
    check("t3_src0", 32'(int_src), 32'd0);
    check("t3_req",  32'(int_req), 32'd1);
    nmi_n = 1'b0;
    cyc(4);
    check("t3_hij",  32'(int_is_nmi), 32'd1);
    check("t3_hsrc", 32'(int_src),    32'd0);
    check("t3_hreq", 32'(int_req),    32'd1);
    ack_once();
    cyc(1);
    check("t3_nclr", 32'(nmi_pending), 32'd0);
    cyc(2);
    check("t3_rreq", 32'(int_req),    32'd1);
    check("t3_rsrc", 32'(int_src),    32'd0);
    check("t3_rnmi", 32'(int_is_nmi), 32'd0);
    ack_once();
    cyc(3);
    check("t3_src3b", 32'(int_src), 32'd3);
    ack_once();
    cyc(3);
    check("t3_done", 32'(int_req), 32'd0);
    check("t3_pd0",  32'(pending), 32'd0);
    src_n = '1; nmi_n = 1'b1;
    cyc(4);

    // Level source, withdraw on i_flag, release
    edge_mode = 4'b1101;
    src_n[1] = 1'b0;
    cyc(4);
    check("t4_req", 32'(int_req), 32'd1);
    check("t4_src", 32'(int_src), 32'd1);
    i_flag = 1'b1;
    cyc(1);
    check("t4_wdr", 32'(int_req),    32'd0);
    check("t4_pd1", 32'(pending[1]), 32'd1);
    src_n[1] = 1'b1;
    cyc(2);
    check("t4_pd1b", 32'(pending[1]), 32'd1);
    cyc(1);
    check("t4_pd1c", 32'(pending[1]), 32'd0);
    i_flag = 1'b0; edge_mode = '1;
    cyc(2);

    // rdy freeze
    rdy = 1'b0;
    nmi_n = 1'b0;
    cyc(1);
    nmi_n = 1'b1;
    cyc(2);
    check("t5_np",  32'(nmi_pending), 32'd1);
    check("t5_rq0", 32'(int_req),     32'd0);
    cyc(2);
    check("t5_rq0b", 32'(int_req), 32'd0);
    rdy = 1'b1;
    cyc(1);
    check("t5_req", 32'(int_req),    32'd1);
    check("t5_nmi", 32'(int_is_nmi), 32'd1);
    rdy = 1'b0; int_ack = 1'b1;
    cyc(2);
    check("t5_ign", 32'(int_req),     32'd1);
    check("t5_npk", 32'(nmi_pending), 32'd1);
    int_ack = 1'b0; rdy = 1'b1;
    cyc(1);
    check("t5_stay", 32'(int_req), 32'd1);
    ack_once();
    cyc(3);
    check("t5_np0", 32'(nmi_pending), 32'd0);
    check("t5_rqx", 32'(int_req),     32'd0);

    // Set beats clear: sw_clr on the detecting edge
    src_n[0] = 1'b0;
    cyc(2);
    sw_clr[0] = 1'b1;
    cyc(1);
    sw_clr = '0;
    check("t6_set", 32'(pending[0]), 32'd1);
    cyc(1);
    check("t6_req", 32'(int_req), 32'd1);
    ack_once();
    cyc(3);
    check("t6_clr", 32'(pending), 32'd0);
    src_n[0] = 1'b1;
    cyc(3);

    // Second NMI edge lands on the SERVICE edge of the first
    nmi_n = 1'b0;
    cyc(1);
    nmi_n = 1'b1;
    cyc(3);
    check("t7_req", 32'(int_req),    32'd1);
    check("t7_nmi", 32'(int_is_nmi), 32'd1);
    nmi_n = 1'b0;
    cyc(1);
    nmi_n = 1'b1; int_ack = 1'b1;
    cyc(1);
    int_ack = 1'b0;
    cyc(1);
    check("t7_keep", 32'(nmi_pending), 32'd1);
    cyc(2);
    check("t7_again", 32'(int_req),    32'd1);
    check("t7_again_nmi", 32'(int_is_nmi), 32'd1);
    ack_once();
    cyc(3);
    check("t7_np0", 32'(nmi_pending), 32'd0);

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] flip;
      if (k == 1500) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      flip = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
      src_n = src_n ^ flip;
      if ($urandom_range(0, 11) == 0) nmi_n = ~nmi_n;
      if ($urandom_range(0, 49) == 0) edge_mode = N'($urandom);
      if ($urandom_range(0, 19) == 0) src_mask = N'($urandom);
      if ($urandom_range(0, 9) == 0) i_flag = ~i_flag;
      for (int b = 0; b < N; b++) sw_clr[b] = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      int_ack = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    int_ack = 1'b0; sw_clr = '0; rdy = 1'b1;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Parametrised NMOS-6502 interrupt front end. Synchronises NUM_SRC active-low IRQ sources plus one NMI line, with a per-source edge/level mode.
- Latches pending state and applies per-source masks and the CPU I flag.
- Arbitrates NMI first, then the lowest source index, and presents one request to the CPU sequencer with a req/ack handshake.
- Sits between the external interrupt pins and the CPU core control FSM.

Parameters:
- NUM_SRC, 4, number of maskable IRQ sources (1..16).
- SYNC_STAGES, 2, flip-flop synchroniser depth on every src_n and nmi_n input (2..4).
- IDX_W, 2, width of int_src; must equal max(1, clog2(NUM_SRC)).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rdy  in  1  CPU ready; 0 freezes the arbitration FSM
- src_n  in  NUM_SRC  active-low IRQ source lines, asynchronous
- nmi_n  in  1  active-low NMI line, asynchronous, always falling-edge
- edge_mode  in  NUM_SRC  per source: 1 = falling-edge latched, 0 = level
- src_mask  in  NUM_SRC  per source: 1 = enabled
- i_flag  in  1  CPU interrupt-disable flag; 1 masks all IRQ sources
- sw_clr  in  NUM_SRC  one-cycle pulses that clear edge-latched pending bits
- int_ack  in  1  CPU accepts the presented interrupt (vector fetch start)
- int_req  out  1  interrupt request to CPU
- int_is_nmi  out  1  presented request is NMI
- int_src  out  IDX_W  index of the presented IRQ source; 0 when int_is_nmi=1
- pending  out  NUM_SRC  raw pending vector, before masking
- nmi_pending  out  1  NMI latched, not yet acknowledged

Behaviour:
- Reset (asynchronous, any state): all synchroniser and previous-value flops go to 1 (inactive). pending=0, nmi_pending=0, int_req=0, int_is_nmi=0, int_src=0, FSM=IDLE.
- Synchronisation: each line passes through SYNC_STAGES flops. A falling edge is prev_sync=1 and sync=0.
- Edge source:
  - pending bit sets on a detected falling edge.
  - It clears on sw_clr, or in SERVICE when that source was acknowledged.
  - If a set and a clear land in the same cycle, set wins.
- Level source: pending bit equals the synchronised inverted line every cycle. sw_clr and ack have no effect.
- NMI: nmi_pending sets on a falling edge and clears only in SERVICE with int_is_nmi=1. Set wins over clear in the same cycle.
- rdy=0:
  - Synchronisers, edge detection and pending latching keep running, so no edge is lost.
  - FSM state and the int_req/int_is_nmi/int_src outputs hold.
  - int_ack is ignored.
- Eligibility: irq_eligible = |(pending & src_mask) & ~i_flag. Any = nmi_pending | irq_eligible.
- Selection: NMI if nmi_pending, else the lowest index i with pending[i] & src_mask[i].
- FSM (advances only when rdy=1):
  - IDLE: int_req=0. If Any, go to REQ; the selection registers into int_is_nmi/int_src on the same edge.
  - REQ: int_req=1.
    - If int_ack, go to SERVICE; outputs hold.
    - Else if NMI is newly pending while an IRQ is presented, stay in REQ and switch to int_is_nmi=1, int_src=0 (hijack).
    - Else if the presented IRQ is no longer eligible (masked, i_flag=1, or a level line released), go back to IDLE with int_req=0 (withdraw).
    - Else stay, and re-register the selection so a higher-priority IRQ can replace the presented one.
  - SERVICE: one cycle, int_req=0. Clear the acknowledged NMI, or the acknowledged edge-source pending bit. Go to HOLDOFF.
  - HOLDOFF: one cycle, int_req=0, no arbitration; this covers the CPU setting the I flag. Go to IDLE.
- Hijack and ack in the same cycle: the ack applies to the registered (old) selection, and the NMI stays pending.
- int_ack while not in REQ: ignored.
- Latency, SYNC_STAGES=2: the src_n/nmi_n fall is captured at edge E. pending is 1 after edge E+2, and int_req is 1 after edge E+3. Minimum ack-to-next-int_req is 3 cycles (SERVICE, HOLDOFF, IDLE).
- Widths: int_src is zero-extended to IDX_W.
- Indices are compared unsigned. No wrap behaviour applies.

Test Plan:
- Reset mid-REQ:
  - Stimulus: edge source 1 presented with int_req=1; reset_n pulsed low asynchronously between clock edges.
  - Required: all outputs 0 immediately; no request after release until a new edge arrives.
- Latency and ack:
  - Stimulus: NUM_SRC=4, edge_mode=4'b1111, src_mask=4'b1111, i_flag=0; src_n[2] falls.
  - Required: pending=4'b0100 after 3 edges; int_req=1, int_src=2 after 4 edges.
  - Stimulus: int_ack for 1 cycle.
  - Required: pending=0 two edges later; int_req stays 0 for 3 cycles.
- Priority and hijack:
  - Stimulus: src 3 presented (int_src=3); src_n[0] falls.
  - Required: int_src becomes 0 while int_req stays 1.
  - Stimulus: nmi_n then falls.
  - Required: int_is_nmi=1, int_src=0.
  - Stimulus: after ack.
  - Required: nmi_pending=0, then int_req=1 with int_src=0 after 3 cycles.
- Level withdraw and masking:
  - Stimulus: level source 1 held low.
  - Required: int_req=1.
  - Stimulus: i_flag set to 1.
  - Required: int_req=0 next edge, pending[1] still 1.
  - Stimulus: src_n[1] released.
  - Required: pending[1]=0 after SYNC_STAGES+1 edges.
- rdy freeze:
  - Stimulus: rdy=0 while in IDLE; nmi_n pulses low for 1 cycle.
  - Required: nmi_pending=1 but int_req stays 0.
  - Stimulus: rdy returns to 1.
  - Required: int_req=1 and int_is_nmi=1 one edge later.
  - Stimulus: int_ack asserted with rdy=0.
  - Required: ignored.
- Set-beats-clear:
  - Stimulus: sw_clr[0] and a detected falling edge of src 0 in the same cycle.
  - Required: pending[0]=1.
  - Stimulus: a second NMI edge during SERVICE of an NMI.
  - Required: nmi_pending stays 1, and int_req=1 again after HOLDOFF.
